inst_fetch_unit: RTL and testbench

//  Fetch side of the instruction-register interface. Holds the program counter and reads

---
 rtl/inst_fetch_unit_if.sv | 24 ++
 rtl/inst_fetch_unit.sv | 121 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// Fetch-side bus bundle: program-memory read handshake plus the IR load handshake.
// The fetch unit is the master of both; memory and IR sit on the slave side.
interface inst_fetch_unit_if #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 12
);
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WORD_SIZE-1:0]  mem_rdata;
    logic                  mem_ack;
    logic                  ir_load;
    logic [WORD_SIZE-1:0]  ir_instr;
    logic                  ir_ready;

    modport master (
        output mem_req, mem_addr, ir_load, ir_instr,
        input  mem_rdata, mem_ack, ir_ready
    );

    modport slave (
        input  mem_req, mem_addr, ir_load, ir_instr,
        output mem_rdata, mem_ack, ir_ready
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads words from program memory over req/ack and
// hands each word to the IR over a valid/ready load handshake. Jumps from the control unit
// redirect the PC; a read already in flight is always completed and its data dropped.
module inst_fetch_unit #(
    parameter int WORD_SIZE  = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int RESET_PC   = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  fetch_en,
    inst_fetch_unit_if.master     bus,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [CNT_WIDTH-1:0]  instr_count
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  ir_load;
    logic [WORD_SIZE-1:0]  ir_instr;
    logic [CNT_WIDTH-1:0]  count;
    logic                  squash;

    logic                  transfer;
    logic [ADDR_WIDTH-1:0] pc_inc;
    logic [ADDR_WIDTH-1:0] pc_after_hold;

    assign transfer      = ir_load & bus.ir_ready;
    assign pc_inc        = pc + ADDR_WIDTH'(1);
    // A jump in HOLD overrides the increment even when the word is taken in the same cycle.
    assign pc_after_hold = jump_valid ? jump_addr : pc_inc;

    assign bus.mem_req  = mem_req;
    assign bus.mem_addr = mem_addr;
    assign bus.ir_load  = ir_load;
    assign bus.ir_instr = ir_instr;
    assign pc_out       = pc;
    assign instr_count  = count;

    // Fetch FSM: all outputs are registered here; squash marks an in-flight read to be dropped.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= S_IDLE;
            pc       <= PC_INIT;
            mem_req  <= 1'b0;
            mem_addr <= PC_INIT;
            ir_load  <= 1'b0;
            ir_instr <= '0;
            count    <= '0;
            squash   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (jump_valid) begin
                        pc <= jump_addr;
                    end else if (fetch_en) begin
                        state    <= S_REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                S_REQ: begin
                    if (!mem_req) begin
                        // Re-issue cycle after a dropped read; mem_addr only moves while req is low.
                        mem_req <= 1'b1;
                        if (jump_valid) begin
                            pc       <= jump_addr;
                            mem_addr <= jump_addr;
                        end else begin
                            mem_addr <= pc;
                        end
                    end else if (bus.mem_ack) begin
                        mem_req <= 1'b0;
                        squash  <= 1'b0;
                        if (jump_valid) begin
                            pc <= jump_addr;
                        end else if (!squash) begin
                            ir_instr <= bus.mem_rdata;
                            ir_load  <= 1'b1;
                            state    <= S_HOLD;
                        end
                    end else if (jump_valid) begin
                        pc     <= jump_addr;
                        squash <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (transfer) begin
                        count <= count + CNT_WIDTH'(1);
                    end
                    if (jump_valid || transfer) begin
                        ir_load <= 1'b0;
                        pc      <= pc_after_hold;
                        if (fetch_en) begin
                            state    <= S_REQ;
                            mem_req  <= 1'b1;
                            mem_addr <= pc_after_hold;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    mem_req <= 1'b0;
                    ir_load <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: a memory responder with configurable ack delay, a transaction
// level reference model (PC, delivered-word queue, counter) in a negedge monitor, directed
// scenarios followed by a randomized run.
module tb_inst_fetch_unit;
    logic        CLK;
    logic        RST;
    logic        fetch_en;
    logic        jump_valid;
    logic [11:0] jump_addr;
    logic [11:0] pc_out;
    logic [15:0] instr_count;

    inst_fetch_unit_if #(.WORD_SIZE(16), .ADDR_WIDTH(12)) bus ();

    inst_fetch_unit #(
        .WORD_SIZE (16),
        .ADDR_WIDTH(12),
        .RESET_PC  (0),
        .CNT_WIDTH (16)
    ) u_dut (
        .CLK        (CLK),
        .RST        (RST),
        .fetch_en   (fetch_en),
        .bus        (bus.master),
        .jump_valid (jump_valid),
        .jump_addr  (jump_addr),
        .pc_out     (pc_out),
        .instr_count(instr_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [15:0] mem [0:4095];
    int          fixed_delay = 1;   // -1 selects a random delay 0..4 per request
    logic        late_ack    = 1'b0;

    logic [15:0] sb[$];
    logic [11:0] req_log[$];
    logic [15:0] xfer_log[$];
    int          xfer_cyc[$];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic fail_to(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [31:0] req_at(input int i);
        return (i < req_log.size()) ? 32'(req_log[i]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] xfer_at(input int i);
        return (i < xfer_log.size()) ? 32'(xfer_log[i]) : 32'hFFFF_FFFF;
    endfunction

    // Memory responder: acks each request after a delay with mem[mem_addr]; can inject a stray ack.
    initial begin
        int wait_cnt;
        int cur_delay;
        bit counting;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        counting      = 0;
        wait_cnt      = 0;
        cur_delay     = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (bus.mem_ack) begin
                bus.mem_ack = 1'b0;
                counting    = 0;
            end else if (late_ack) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 16'hDEAD;
            end else if (!bus.mem_req) begin
                counting = 0;
            end else begin
                if (!counting) begin
                    counting  = 1;
                    wait_cnt  = 0;
                    cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
                end
                if (wait_cnt >= cur_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr];
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: reference model of PC / count / delivered words, checked every cycle.
    initial begin
        logic [11:0] m_pc;
        logic [15:0] m_cnt;
        logic [11:0] req_addr;
        logic [15:0] hold_word;
        logic [15:0] w;
        bit          prev_req;
        bit          tainted;
        bit          hold_valid;
        int          exp_load;
        m_pc = 0; m_cnt = 0; req_addr = 0; hold_word = 0;
        prev_req = 0; tainted = 0; hold_valid = 0; exp_load = -1;
        forever begin
            @(negedge CLK);
            if (RST) begin
                m_pc = 12'h000;
                m_cnt = 16'h0000;
                sb.delete();
                prev_req = 0;
                tainted = 0;
                hold_valid = 0;
                exp_load = -1;
                continue;
            end
            chk("pc_out", 32'(pc_out), 32'(m_pc));
            chk("instr_count", 32'(instr_count), 32'(m_cnt));
            if (exp_load >= 0) begin
                chk("ir_load_timing", 32'(bus.ir_load), 32'(exp_load));
                if (hold_valid) chk("ir_instr_hold", 32'(bus.ir_instr), 32'(hold_word));
            end
            exp_load = -1;
            hold_valid = 0;
            if (bus.ir_load) chk("req_during_load", 32'(bus.mem_req), 32'd0);

            if (bus.mem_req) begin
                if (!prev_req) begin
                    chk("req_addr", 32'(bus.mem_addr), 32'(m_pc));
                    req_addr = bus.mem_addr;
                    tainted  = 0;
                    req_log.push_back(bus.mem_addr);
                end else begin
                    chk("req_addr_stable", 32'(bus.mem_addr), 32'(req_addr));
                end
                if (jump_valid) tainted = 1;
                if (bus.mem_ack) begin
                    if (!tainted) begin
                        sb.push_back(mem[req_addr]);
                        exp_load = 1;
                    end else begin
                        exp_load = 0;
                    end
                end
            end
            prev_req = bus.mem_req && !bus.mem_ack;

            if (bus.ir_load) begin
                if (bus.ir_ready) begin
                    if (sb.size() == 0) begin
                        fail_to("sb_underflow");
                    end else begin
                        w = sb.pop_front();
                        chk("ir_instr", 32'(bus.ir_instr), 32'(w));
                    end
                    xfer_log.push_back(bus.ir_instr);
                    xfer_cyc.push_back(cyc);
                    exp_load = 0;
                end else if (jump_valid) begin
                    if (sb.size() > 0) w = sb.pop_front();
                    exp_load = 0;
                end else begin
                    exp_load   = 1;
                    hold_valid = 1;
                    hold_word  = bus.ir_instr;
                end
            end

            if (jump_valid) m_pc = jump_addr;
            else if (bus.ir_load && bus.ir_ready) m_pc = m_pc + 12'd1;
            if (bus.ir_load && bus.ir_ready) m_cnt = m_cnt + 16'd1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic wait_count(input logic [15:0] tgt, input string nm);
        int i;
        for (i = 0; i < 300 && instr_count != tgt; i++) step(1);
        if (instr_count != tgt) fail_to(nm);
    endtask

    task automatic wait_load(input string nm);
        int i;
        for (i = 0; i < 300 && !bus.ir_load; i++) step(1);
        if (!bus.ir_load) fail_to(nm);
    endtask

    task automatic wait_req(input string nm);
        int i;
        for (i = 0; i < 300 && !bus.mem_req; i++) step(1);
        if (!bus.mem_req) fail_to(nm);
    endtask

    task automatic drain(input string nm);
        fetch_en    = 1'b0;
        jump_valid  = 1'b0;
        bus.ir_ready = 1'b1;
        step(30);
        chk({nm, "_idle_req"}, 32'(bus.mem_req), 32'd0);
        chk({nm, "_idle_load"}, 32'(bus.ir_load), 32'd0);
    endtask

    task automatic jump_idle(input logic [11:0] a);
        jump_valid = 1'b1;
        jump_addr  = a;
        step(1);
        jump_valid = 1'b0;
    endtask

    initial begin
        int idx;
        int xidx;
        logic [15:0] c0;
        logic [15:0] w0;
        logic [11:0] p0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        mem[0]     = 16'h1ABC;
        mem[1]     = 16'h2DEF;
        mem[3]     = 16'h3333;
        mem[12'h100] = 16'h5100;

        RST = 1'b1; fetch_en = 1'b0; jump_valid = 1'b0; jump_addr = '0; bus.ir_ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        step(1);
        chk("rst_pc", 32'(pc_out), 32'h000);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_ir_load", 32'(bus.ir_load), 32'd0);
        chk("rst_ir_instr", 32'(bus.ir_instr), 32'h0);
        chk("rst_count", 32'(instr_count), 32'd0);

        // Basic fetch of two words from address 0.
        fixed_delay = 1; bus.ir_ready = 1'b1; fetch_en = 1'b1;
        wait_count(16'd2, "basic_count");
        chk("basic_pc", 32'(pc_out), 32'h002);
        drain("basic");
        chk("basic_addr0", req_at(0), 32'h000);
        chk("basic_addr1", req_at(1), 32'h001);
        chk("basic_word0", xfer_at(0), 32'h1ABC);
        chk("basic_word1", xfer_at(1), 32'h2DEF);

        // Throughput with a registered (1-cycle) memory.
        c0 = instr_count; xfer_cyc.delete(); fetch_en = 1'b1;
        wait_count(c0 + 16'd3, "tput_count");
        drain("tput");
        if (xfer_cyc.size() >= 3) begin
            chk("tput_gap1", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'd3);
            chk("tput_gap2", 32'(xfer_cyc[2] - xfer_cyc[1]), 32'd3);
        end else fail_to("tput_samples");

        // IR backpressure.
        bus.ir_ready = 1'b0; fetch_en = 1'b1;
        wait_load("bp_load");
        fetch_en = 1'b0;
        w0 = bus.ir_instr; p0 = pc_out; c0 = instr_count;
        for (int i = 0; i < 5; i++) begin
            step(1);
            chk("bp_load", 32'(bus.ir_load), 32'd1);
            chk("bp_instr", 32'(bus.ir_instr), 32'(w0));
            chk("bp_req", 32'(bus.mem_req), 32'd0);
            chk("bp_pc", 32'(pc_out), 32'(p0));
            chk("bp_count", 32'(instr_count), 32'(c0));
        end
        drain("bp");

        // Jump while a request at 3 is outstanding.
        jump_idle(12'h003);
        chk("j3_pc", 32'(pc_out), 32'h003);
        idx = req_log.size(); xidx = xfer_log.size(); c0 = instr_count;
        fixed_delay = 4; fetch_en = 1'b1;
        wait_req("j3_req");
        chk("j3_req_addr", 32'(bus.mem_addr), 32'h003);
        jump_valid = 1'b1; jump_addr = 12'h100;
        step(1);
        jump_valid = 1'b0;
        wait_count(c0 + 16'd1, "j3_count");
        drain("j3");
        chk("j3_log_a", req_at(idx), 32'h003);
        chk("j3_log_b", req_at(idx + 1), 32'h100);
        chk("j3_first_word", xfer_at(xidx), 32'h5100);

        // Jump in HOLD coinciding with a transfer.
        fixed_delay = 1; bus.ir_ready = 1'b0; fetch_en = 1'b1;
        wait_load("jh_load");
        fetch_en = 1'b0; c0 = instr_count;
        bus.ir_ready = 1'b1; jump_valid = 1'b1; jump_addr = 12'h2A0;
        step(1);
        jump_valid = 1'b0;
        chk("jh_count", 32'(instr_count), 32'(c0 + 16'd1));
        chk("jh_pc", 32'(pc_out), 32'h2A0);
        chk("jh_load_low", 32'(bus.ir_load), 32'd0);
        step(5);
        chk("jh_no_req", 32'(bus.mem_req), 32'd0);

        // PC wrap from the top of the address space.
        jump_idle(12'hFFF);
        idx = req_log.size(); c0 = instr_count; fetch_en = 1'b1;
        wait_count(c0 + 16'd2, "wrap_count");
        drain("wrap");
        chk("wrap_addr0", req_at(idx), 32'hFFF);
        chk("wrap_addr1", req_at(idx + 1), 32'h000);

        // Asynchronous reset mid-request, then a stray ack.
        jump_idle(12'h055);
        fixed_delay = 8; fetch_en = 1'b1;
        wait_req("ar_req");
        fetch_en = 1'b0;
        step(1);
        #1 RST = 1'b1;
        #1;
        chk("ar_mem_req", 32'(bus.mem_req), 32'd0);
        chk("ar_ir_load", 32'(bus.ir_load), 32'd0);
        chk("ar_pc", 32'(pc_out), 32'h000);
        chk("ar_count", 32'(instr_count), 32'd0);
        chk("ar_ir_instr", 32'(bus.ir_instr), 32'h0);
        @(posedge CLK);
        #1 RST = 1'b0;
        step(1);
        #1 late_ack = 1'b1;
        @(posedge CLK);
        #2 late_ack = 1'b0;
        step(3);
        chk("late_ir_load", 32'(bus.ir_load), 32'd0);
        chk("late_ir_instr", 32'(bus.ir_instr), 32'h0);
        chk("late_mem_req", 32'(bus.mem_req), 32'd0);

        // Randomized run against the reference model.
        fixed_delay = -1;
        for (int i = 0; i < 1500; i++) begin
            fetch_en     = ($urandom_range(0, 9) != 0);
            bus.ir_ready = ($urandom_range(0, 9) < 7);
            jump_valid   = ($urandom_range(0, 24) == 0);
            jump_addr    = ($urandom_range(0, 3) == 0) ? 12'hFFE + 12'($urandom_range(0, 1))
                                                       : 12'($urandom_range(0, 4095));
            step(1);
        end
        drain("rand");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
